// File: rtl/operand_fetch.sv
// Two-stage operand fetch: S1 holds a request while its register-file read is
// in flight, OUT holds the resolved operand pair with write-back forwarding.
module operand_fetch #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS  = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic [AW-1:0]        reqRs1,
  input  logic [AW-1:0]        reqRs2,
  output logic [AW-1:0]        rfRs1Addr,
  output logic [AW-1:0]        rfRs2Addr,
  input  logic [REG_WIDTH-1:0] rfRs1Data,
  input  logic [REG_WIDTH-1:0] rfRs2Data,
  input  logic                 wbEn,
  input  logic [AW-1:0]        wbAddr,
  input  logic [REG_WIDTH-1:0] wbData,
  output logic                 opValid,
  input  logic                 opReady,
  output logic [REG_WIDTH-1:0] op1,
  output logic [REG_WIDTH-1:0] op2
);

  logic                 s1_valid;
  logic [AW-1:0]        s1_rs1;
  logic [AW-1:0]        s1_rs2;
  logic                 byp1_flag;
  logic                 byp2_flag;
  logic [REG_WIDTH-1:0] byp1_val;
  logic [REG_WIDTH-1:0] byp2_val;
  logic [AW-1:0]        out_rs1;
  logic [AW-1:0]        out_rs2;
  logic                 advance;
  logic                 accept;
  logic                 sample;
  logic [REG_WIDTH-1:0] cand1;
  logic [REG_WIDTH-1:0] cand2;

  // A write hits a source only when enabled, matching, and not to x0.
  function automatic logic wb_hit(input logic en, input logic [AW-1:0] waddr,
                                  input logic [AW-1:0] src);
    return en && (waddr == src) && (src != {AW{1'b0}});
  endfunction

  function automatic logic [REG_WIDTH-1:0] pick(
    input logic [AW-1:0]        src,
    input logic                 en,
    input logic [AW-1:0]        waddr,
    input logic [REG_WIDTH-1:0] wdata,
    input logic                 flag,
    input logic [REG_WIDTH-1:0] bval,
    input logic [REG_WIDTH-1:0] rdata
  );
    if (src == {AW{1'b0}}) begin
      return {REG_WIDTH{1'b0}};
    end else if (en && (waddr == src)) begin
      return wdata;
    end else if (flag) begin
      return bval;
    end else begin
      return rdata;
    end
  endfunction

  assign advance   = s1_valid && (!opValid || opReady);
  assign reqReady  = !s1_valid || advance;
  assign accept    = reqValid && reqReady;
  // A stalled S1 keeps re-reading its own addresses so the data stays fresh.
  assign rfRs1Addr = (s1_valid && !advance) ? s1_rs1 : reqRs1;
  assign rfRs2Addr = (s1_valid && !advance) ? s1_rs2 : reqRs2;
  assign sample    = accept || (s1_valid && !advance);

  assign cand1 = pick(s1_rs1, wbEn, wbAddr, wbData, byp1_flag, byp1_val, rfRs1Data);
  assign cand2 = pick(s1_rs2, wbEn, wbAddr, wbData, byp2_flag, byp2_val, rfRs2Data);

  // S1 stage: request capture plus capture of writes racing the RF read.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_valid  <= 1'b0;
      s1_rs1    <= {AW{1'b0}};
      s1_rs2    <= {AW{1'b0}};
      byp1_flag <= 1'b0;
      byp2_flag <= 1'b0;
      byp1_val  <= {REG_WIDTH{1'b0}};
      byp2_val  <= {REG_WIDTH{1'b0}};
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_rs1   <= reqRs1;
        s1_rs2   <= reqRs2;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end else begin
        s1_valid <= s1_valid;
      end
      if (sample) begin
        byp1_flag <= wb_hit(wbEn, wbAddr, rfRs1Addr);
        byp2_flag <= wb_hit(wbEn, wbAddr, rfRs2Addr);
        byp1_val  <= wbData;
        byp2_val  <= wbData;
      end else begin
        byp1_flag <= 1'b0;
        byp2_flag <= 1'b0;
      end
    end
  end

  // OUT stage: operand pair, kept coherent with writes while backpressured.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      opValid <= 1'b0;
      op1     <= {REG_WIDTH{1'b0}};
      op2     <= {REG_WIDTH{1'b0}};
      out_rs1 <= {AW{1'b0}};
      out_rs2 <= {AW{1'b0}};
    end else if (advance) begin
      opValid <= 1'b1;
      op1     <= cand1;
      op2     <= cand2;
      out_rs1 <= s1_rs1;
      out_rs2 <= s1_rs2;
    end else if (opValid && opReady) begin
      opValid <= 1'b0;
    end else if (opValid) begin
      if (wb_hit(wbEn, wbAddr, out_rs1)) begin
        op1 <= wbData;
      end
      if (wb_hit(wbEn, wbAddr, out_rs2)) begin
        op2 <= wbData;
      end
    end else begin
      opValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a registered-read register file model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic [4:0]  reqRs1;
  logic [4:0]  reqRs2;
  logic [4:0]  rfRs1Addr;
  logic [4:0]  rfRs2Addr;
  logic [31:0] rfRs1Data;
  logic [31:0] rfRs2Data;
  logic        wbEn;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        opValid;
  logic        opReady;
  logic [31:0] op1;
  logic [31:0] op2;

  logic [31:0] mem [32];
  int n_vec = 0;
  int n_err = 0;

  operand_fetch #(.REG_WIDTH(32), .NUM_REGS(32)) dut (
    .clk(clk), .rstN(rstN),
    .reqValid(reqValid), .reqReady(reqReady), .reqRs1(reqRs1), .reqRs2(reqRs2),
    .rfRs1Addr(rfRs1Addr), .rfRs2Addr(rfRs2Addr),
    .rfRs1Data(rfRs1Data), .rfRs2Data(rfRs2Data),
    .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
    .opValid(opValid), .opReady(opReady), .op1(op1), .op2(op2)
  );

  always #5 clk = ~clk;

  // Register file: read data registered one cycle after the address, old value on collision.
  always @(posedge clk) begin
    rfRs1Data <= mem[rfRs1Addr];
    rfRs2Data <= mem[rfRs2Addr];
    if (wbEn) mem[wbAddr] <= wbData;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [4:0] a, input logic [4:0] b);
    reqValid = 1'b1;
    reqRs1   = a;
    reqRs2   = b;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wbEn   = en;
    wbAddr = a;
    wbData = d;
  endtask

  task automatic chk_op(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    check({tag, " valid"}, 32'(opValid), 32'd1);
    check({tag, " op1"}, op1, e1);
    check({tag, " op2"}, op2, e2);
  endtask

  initial begin
    rstN = 1'b0; opReady = 1'b1; reqValid = 1'b0; reqRs1 = 5'd0; reqRs2 = 5'd0;
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) step();
    reqRs1 = 5'd7; reqRs2 = 5'd3;
    #1;
    check("rst opValid", 32'(opValid), 32'd0);
    check("rst op1", op1, 32'h0);
    check("rst op2", op2, 32'h0);
    check("rst reqReady", 32'(reqReady), 32'd1);
    check("rst rf1addr", 32'(rfRs1Addr), 32'd7);
    check("rst rf2addr", 32'(rfRs2Addr), 32'd3);
    rstN = 1'b1;

    // preload the register file through the write port
    wb(1'b1, 5'd5, 32'h11); step();
    wb(1'b1, 5'd6, 32'h22); step();
    wb(1'b1, 5'd7, 32'h33); step();
    wb(1'b1, 5'd8, 32'h44); step();
    wb(1'b1, 5'd9, 32'h55); step();
    wb(1'b0, 5'd0, 32'h0);

    // basic read, 2-edge latency
    req(5'd5, 5'd6); step();
    reqValid = 1'b0;
    check("basic lat1 valid", 32'(opValid), 32'd0);
    step();
    chk_op("basic", 32'h11, 32'h22);
    step();
    check("basic drain", 32'(opValid), 32'd0);

    // write at the acceptance edge
    req(5'd5, 5'd6); wb(1'b1, 5'd5, 32'hAA); step();
    reqValid = 1'b0; wb(1'b0, 5'd0, 32'h0); step();
    chk_op("accept byp", 32'hAA, 32'h22);
    step();

    // write in the advance cycle
    req(5'd5, 5'd6); step();
    reqValid = 1'b0; wb(1'b1, 5'd6, 32'hBB); step();
    wb(1'b0, 5'd0, 32'h0);
    chk_op("adv byp", 32'hAA, 32'hBB);
    step();

    // x0 with simultaneous writes to x0
    req(5'd0, 5'd0); wb(1'b1, 5'd0, 32'hFF); step();
    reqValid = 1'b0; step();
    wb(1'b0, 5'd0, 32'h0);
    chk_op("x0 wr", 32'h0, 32'h0);
    step();
    req(5'd0, 5'd0); step();
    reqValid = 1'b0; step();
    chk_op("x0 rf", 32'h0, 32'h0);
    step();

    // back-to-back throughput
    req(5'd7, 5'd8); step();
    check("tput ready", 32'(reqReady), 32'd1);
    req(5'd8, 5'd9); step();
    chk_op("tput A", 32'h33, 32'h44);
    req(5'd9, 5'd7); step();
    chk_op("tput B", 32'h44, 32'h55);
    reqValid = 1'b0; step();
    chk_op("tput C", 32'h55, 32'h33);
    step();
    check("tput drain", 32'(opValid), 32'd0);

    // backpressure: 5 edges with opReady low, 3 requests offered
    opReady = 1'b0;
    req(5'd5, 5'd7); step();
    req(5'd6, 5'd8);
    check("bp ready2", 32'(reqReady), 32'd1);
    step();
    req(5'd9, 5'd9);
    check("bp ready3", 32'(reqReady), 32'd0);
    chk_op("bp P", 32'hAA, 32'h33);
    wb(1'b1, 5'd7, 32'h77); step();
    check("bp held upd", op2, 32'h77);
    wb(1'b1, 5'd8, 32'h88); step();
    wb(1'b0, 5'd0, 32'h0); step();
    check("bp ready end", 32'(reqReady), 32'd0);
    chk_op("bp P end", 32'hAA, 32'h77);
    opReady = 1'b1;
    #1;
    check("bp release ready", 32'(reqReady), 32'd1);
    step();
    reqValid = 1'b0;
    chk_op("bp Q", 32'hBB, 32'h88);
    step();
    chk_op("bp R", 32'h55, 32'h55);
    step();
    check("bp drain", 32'(opValid), 32'd0);

    // reset with S1 and OUT both full
    opReady = 1'b0;
    req(5'd7, 5'd8); step();
    req(5'd9, 5'd5); step();
    reqValid = 1'b0;
    chk_op("pre rst", 32'h77, 32'h88);
    rstN = 1'b0;
    #1;
    check("mid rst opValid", 32'(opValid), 32'd0);
    check("mid rst op1", op1, 32'h0);
    check("mid rst op2", op2, 32'h0);
    check("mid rst ready", 32'(reqReady), 32'd1);
    step(); step();
    rstN = 1'b1; opReady = 1'b1;
    step();
    check("no stale 1", 32'(opValid), 32'd0);
    step();
    check("no stale 2", 32'(opValid), 32'd0);
    req(5'd5, 5'd6); step();
    reqValid = 1'b0; step();
    chk_op("post rst", 32'hAA, 32'hBB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
